// File: rtl/cpu_perf_pkg.sv
// Shared constants for the CPU performance monitor: query selectors,
// query FSM state encoding and default counter width.
package cpu_perf_pkg;
  localparam int CNT_W_DEF = 32;

  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_STALL  = 2'd1;
  localparam logic [1:0] SEL_FLUSH  = 2'd2;
  localparam logic [1:0] SEL_RETIRE = 2'd3;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
endpackage

// File: rtl/perf_counter.sv
// One event counter with synchronous clear. Wraps modulo 2^CNT_W by default;
// with PERF_SATURATE_EN defined it sticks at all-ones until clear/reset.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
`ifdef PERF_SATURATE_EN
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
`else
      cnt <= cnt + CNT_W'(1);
`endif
    end
  end
endmodule

// File: rtl/cpu_perf_monitor.sv
// Cycle/stall/flush/retire counters with a valid/ready query port.
// Counter overflow behaviour selected by PERF_SATURATE_EN (see perf_counter).
module cpu_perf_monitor
  import cpu_perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             req_valid_i,
  input  logic [1:0]       req_sel_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  output logic [CNT_W-1:0] rsp_data_o,
  input  logic             rsp_ready_i
);
  logic [3:0]            inc;
  logic [3:0][CNT_W-1:0] cnt;
  state_t                state;

  // Bit order matches the SEL_* encoding; stalls during a branch are not load-use stalls.
  assign inc = {retire_i, flush_i, stall_i & ~branch_i, 1'b1} & {4{start_i}};

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk_i),
      .rst_n(rst_i),
      .en   (inc[i]),
      .clr  (clear_i),
      .cnt  (cnt[i])
    );
  end

  // Capture reads the registered value, i.e. before this edge's increment or clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          rsp_data_o  <= cnt[req_sel_i];
          rsp_valid_o <= 1'b1;
          req_ready_o <= 1'b0;
          state       <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Directed bench for cpu_perf_monitor: a counter model plus a response scoreboard
// on a 32-bit instance, and a 4-bit instance for the overflow behaviour.
module tb_cpu_perf_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, branch, flush, retire, clear;
  logic        req_valid, rsp_ready;
  logic [1:0]  req_sel;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_data;

  logic        w_start, w_retire, w_req, w_rsp_ready;
  logic        w_req_ready, w_rsp_valid;
  logic [3:0]  w_rsp_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m [4];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  cpu_perf_monitor #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .clear_i(clear), .req_valid_i(req_valid),
    .req_sel_i(req_sel), .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready)
  );

  cpu_perf_monitor #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(w_start), .stall_i(1'b0), .branch_i(1'b0),
    .flush_i(1'b0), .retire_i(w_retire), .clear_i(1'b0), .req_valid_i(w_req),
    .req_sel_i(2'd3), .req_ready_o(w_req_ready), .rsp_valid_o(w_rsp_valid),
    .rsp_data_o(w_rsp_data), .rsp_ready_i(w_rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    logic [31:0] n [4];
    n = m;
    if (clear) begin
      n = '{default: 32'd0};
    end else if (start) begin
      n[0] = m[0] + 1;
      n[1] = m[1] + 32'(stall & ~branch);
      n[2] = m[2] + 32'(flush);
      n[3] = m[3] + 32'(retire);
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int budget = 10;
    while (!rsp_valid && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic query(input logic [1:0] sel, input string tag);
    logic [31:0] exp;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_sel = sel;
    sb.push_back(m[sel]);
    tick();
    req_valid = 1'b0;
    check({tag, "_lat"}, 32'(rsp_valid), 32'd1);
    wait_rsp({tag, "_valid"});
    exp = sb.pop_front();
    check({tag, "_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic wquery(input logic [3:0] exp, input string tag);
    w_req = 1'b1;
    tick();
    w_req = 1'b0;
    check({tag, "_valid"}, 32'(w_rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(w_rsp_data), 32'(exp));
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    m = '{default: 32'd0};
    {start, stall, branch, flush, retire, clear, req_valid, rsp_ready} = '0;
    req_sel = 2'd0;
    {w_start, w_retire, w_req, w_rsp_ready} = '0;

    // 1. reset, then 10 counted cycles and a cycle query
    rst_n = 1'b0;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    start = 1'b1;
    repeat (10) tick();
    check("model_cycle10", m[0], 32'd10);
    query(2'd0, "cycle10");

    // 2. stall qualification by branch, flush pulses
    stall = 1'b1; branch = 1'b1; tick(); tick();
    branch = 1'b0; tick();
    stall = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0; tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("model_stall1", m[1], 32'd1);
    query(2'd1, "stall");
    query(2'd2, "flush");

    // 3. response held under backpressure; new requests ignored
    req_valid = 1'b1; req_sel = 2'd0;
    sb.push_back(m[0]);
    tick();
    req_sel = 2'd2;
    held = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, held);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    tick();
    check("idle_data_hold", rsp_data, held);

    // 4. clear beats retire; same-cycle query returns the pre-clear value
    retire = 1'b1; repeat (3) tick();
    clear = 1'b1; req_valid = 1'b1; req_sel = 2'd3;
    sb.push_back(m[3]);
    tick();
    clear = 1'b0; retire = 1'b0; req_valid = 1'b0;
    check("clr_old_nonzero", sb[0], 32'd3);
    wait_rsp("clr_valid");
    check("clr_old_data", rsp_data, sb.pop_front());
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    query(2'd3, "retire_after_clr");
    query(2'd0, "cycle_after_clr");

    // 5. 4-bit overflow: 15 events, then 2 more
    w_start = 1'b1; w_retire = 1'b1;
    repeat (15) tick();
    w_retire = 1'b0;
    wquery(4'd15, "w15");
    w_retire = 1'b1;
    repeat (2) tick();
    w_retire = 1'b0;
`ifdef PERF_SATURATE_EN
    wquery(4'd15, "w17_sat");
`else
    wquery(4'd1, "w17_wrap");
`endif

    // 6. async reset while a response is pending
    req_valid = 1'b1; req_sel = 2'd0;
    tick();
    req_valid = 1'b0;
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd1);
    check("async_rsp_data", rsp_data, 32'd0);
    sb.delete();
    start = 1'b0;
    m = '{default: 32'd0};
    tick();
    rst_n = 1'b1;
    tick();
    query(2'd0, "cycle_post_rst");
    query(2'd3, "retire_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
